// File: rtl/fetch_if.sv
// fetch_if: bundles every fetch-path signal between the fetch sequencer and
// its neighbours (PC register, instruction memory, execute, decode).
//
// Handshake: decode takes an instruction on a rising clk edge where
// instr_valid & instr_ready are both 1. While instr_valid=1 and
// instr_ready=0, instr/instr_pc/instr_valid hold their values.
// instr_valid does not depend on instr_ready.
//
// Modports
//   master : the fetch sequencer
//            drives pc_step, pc_enable, imem_addr, imem_rd, instr, instr_pc, instr_valid
//   slave  : the surrounding datapath
//            drives pc, imem_data, instr_ready, branch_taken, branch_target, halt
interface fetch_if #(
  parameter int ADDR_W  = 15,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_step;
  logic               pc_enable;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               halt;

  modport master (
    input  pc, imem_data, instr_ready, branch_taken, branch_target, halt,
    output pc_step, pc_enable, imem_addr, imem_rd, instr, instr_pc, instr_valid
  );

  modport slave (
    output pc, imem_data, instr_ready, branch_taken, branch_target, halt,
    input  pc_step, pc_enable, imem_addr, imem_rd, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: chooses the next PC (sequential +1 or branch target),
// reads instruction memory and hands each fetched word to decode.
//
// Ports
//   clk      : clock, all state updates on posedge
//   reset    : synchronous, active-high
//   bus      : fetch_if.master (PC register, instruction memory, decode, redirect)
//   state_o  : current FSM state (0 FETCH, 1 WAIT, 2 OUT, 3 HALT) for debug
//
// One instruction is handled every three cycles: FETCH issues the read,
// WAIT captures the data and advances the PC, OUT presents it to decode.
// A branch overrides everything else that cycle. While reset is high the
// PC strobe and read strobe are forced low, so the PC register's own reset
// takes effect.
module fetch_sequencer #(
  parameter int ADDR_W  = 15,
  parameter int INSTR_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  fetch_if.master    bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_inc;

  // Natural wrap: the top address steps to 0.
  assign pc_inc = bus.pc + PC_ONE;

  assign bus.imem_addr   = bus.pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign state_o         = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    valid_d       = valid_q;
    bus.pc_enable = 1'b0;
    bus.pc_step   = pc_inc;
    bus.imem_rd   = 1'b0;

    if (reset) begin
      // Strobes stay low; registers are cleared by the sequential block.
    end else if (bus.branch_taken) begin
      // Redirect wins: load the target, drop any read in flight or any
      // instruction on offer (an OUT handshake this cycle still completes).
      bus.pc_enable = 1'b1;
      bus.pc_step   = bus.branch_target;
      valid_d       = 1'b0;
      state_d       = bus.halt ? S_HALT : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.halt) begin
            state_d = S_HALT;
          end else begin
            bus.imem_rd = 1'b1;
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          // pc has not moved since FETCH, so it is the fetch address.
          instr_d       = bus.imem_data;
          instr_pc_d    = bus.pc;
          valid_d       = 1'b1;
          bus.pc_enable = 1'b1;
          state_d       = S_OUT;
        end
        S_OUT: begin
          if (valid_q && bus.instr_ready) begin
            valid_d = 1'b0;
            state_d = bus.halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          if (!bus.halt) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a random run.
// The PC register and a 1-cycle-latency instruction memory are modelled
// here. The scoreboard treats the fetch stream as a sequence of addresses:
// decode must see consecutive addresses (mod 2^15) with matching memory
// words, restarting at 0 on reset and at the target on every branch.
module tb_fetch_sequencer;
  localparam int ADDR_W  = 15;
  localparam int INSTR_W = 16;
  localparam int W       = ADDR_W + INSTR_W;

  logic       clk;
  logic       reset;
  logic [1:0] state;

  fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- environment ----------------
  logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];

  // PC register: enable has priority over its own reset.
  always @(posedge clk) begin
    if (bus.pc_enable)  bus.pc <= bus.pc_step;
    else if (reset)     bus.pc <= '0;
  end

  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] en_log[$];
  logic              prev_en;
  logic              prev_hold;
  logic [W:0]        hold_val;
  int                accepted;

  initial begin
    prev_en   = 1'b0;
    prev_hold = 1'b0;
    hold_val  = '0;
    accepted  = 0;
  end

  always @(negedge clk) begin
    logic [W-1:0]      e;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] seq_pc;
    if (reset) begin
      check("rst_pc_enable", bus.pc_enable, 0);
      check("rst_imem_rd", bus.imem_rd, 0);
      exp_q.delete();
      exp_q.push_back({{ADDR_W{1'b0}}, mem[0]});
      prev_en   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      seq_pc = bus.pc + 15'd1;
      check("imem_addr", bus.imem_addr, bus.pc);
      if (bus.instr_valid) check("rd_while_valid", bus.imem_rd, 0);
      if (bus.branch_taken) begin
        check("br_enable", bus.pc_enable, 1);
        check("br_step", bus.pc_step, bus.branch_target);
        check("br_rd", bus.imem_rd, 0);
      end else if (bus.pc_enable) begin
        check("seq_step", bus.pc_step, seq_pc);
        check("en_b2b", {prev_en, bus.pc_enable}, 2'b01);
      end
      if (bus.pc_enable) en_log.push_back(bus.pc_step);
      if (prev_hold)
        check("hold_stable", {bus.instr_valid, bus.instr_pc, bus.instr}, hold_val);
      if (bus.instr_valid && bus.instr_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check("xfer_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("xfer", {bus.instr_pc, bus.instr}, e);
          nxt = e[W-1:INSTR_W] + 15'd1;
          exp_q.push_back({nxt, mem[nxt]});
        end
      end
      if (bus.branch_taken) begin
        exp_q.delete();
        exp_q.push_back({bus.branch_target, mem[bus.branch_target]});
      end
      prev_hold = bus.instr_valid && !bus.instr_ready && !bus.branch_taken;
      hold_val  = {bus.instr_valid, bus.instr_pc, bus.instr};
      prev_en   = bus.pc_enable;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance cycle by cycle until instr_valid is seen at a negedge;
  // n = clock edges taken.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
      @(negedge clk);
    end while (!bus.instr_valid && n < max);
    check("valid_seen", bus.instr_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [ADDR_W-1:0] saved_pc;
    logic [INSTR_W-1:0] saved_instr;

    reset             = 1'b1;
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.halt          = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = INSTR_W'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;

    // 1: first fetches, latency and spacing
    repeat (3) tick();
    reset = 1'b0;
    en_log.delete();
    wait_valid(6, n);
    check("t1_first_latency", n, 2);
    check("t1_pc0", bus.instr_pc, 0);
    check("t1_instr0", bus.instr, 16'h1111);
    wait_valid(6, n);
    check("t1_spacing1", n, 3);
    check("t1_pc1", bus.instr_pc, 1);
    check("t1_instr1", bus.instr, 16'h2222);
    wait_valid(6, n);
    check("t1_spacing2", n, 3);
    check("t1_pc2", bus.instr_pc, 2);
    check("t1_instr2", bus.instr, 16'h3333);
    check("t1_en_count", en_log.size(), 3);
    check("t1_step0", en_log[0], 1);
    check("t1_step1", en_log[1], 2);
    check("t1_step2", en_log[2], 3);

    // 2: back-pressure
    tick();
    bus.instr_ready = 1'b0;
    wait_valid(6, n);
    check("t2_pc", bus.instr_pc, 3);
    saved_pc    = bus.instr_pc;
    saved_instr = bus.instr;
    for (int i = 0; i < 6; i++) begin
      check("t2_valid", bus.instr_valid, 1);
      check("t2_instr", bus.instr, saved_instr);
      check("t2_instr_pc", bus.instr_pc, saved_pc);
      check("t2_rd", bus.imem_rd, 0);
      check("t2_en", bus.pc_enable, 0);
      tick();
      @(negedge clk);
    end
    tick();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_before_accept", bus.instr_valid, 1);
    tick();
    @(negedge clk);
    check("t2_refetch_rd", bus.imem_rd, 1);
    check("t2_refetch_addr", bus.imem_addr, 4);

    // 3: branch during WAIT at pc=5
    wait_valid(6, n);
    check("t3_pc4", bus.instr_pc, 4);
    tick();
    @(negedge clk);
    check("t3_fetch5_addr", bus.imem_addr, 5);
    check("t3_fetch5_rd", bus.imem_rd, 1);
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 15'h0100;
    @(negedge clk);
    check("t3_br_en", bus.pc_enable, 1);
    check("t3_br_step", bus.pc_step, 15'h0100);
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("t3_no_valid5", bus.instr_valid, 0);
    check("t3_redirect_addr", bus.imem_addr, 15'h0100);
    wait_valid(6, n);
    check("t3_latency", n, 2);
    check("t3_pc", bus.instr_pc, 15'h0100);
    check("t3_instr", bus.instr, mem[15'h0100]);

    // 4: wrap at the top of the address space
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 15'h7FFF;
    @(negedge clk);
    check("t4_br_step", bus.pc_step, 15'h7FFF);
    tick();
    bus.branch_taken = 1'b0;
    en_log.delete();
    wait_valid(6, n);
    check("t4_pc_top", bus.instr_pc, 15'h7FFF);
    check("t4_instr_top", bus.instr, mem[15'h7FFF]);
    check("t4_en_count", en_log.size(), 1);
    check("t4_wrap_step", en_log[0], 0);
    wait_valid(6, n);
    check("t4_pc_wrapped", bus.instr_pc, 0);

    // 5: halt in FETCH
    tick();
    bus.halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_rd", bus.imem_rd, 0);
      check("t5_en", bus.pc_enable, 0);
      check("t5_valid", bus.instr_valid, 0);
      tick();
    end
    bus.halt = 1'b0;
    @(negedge clk);
    check("t5_release_rd", bus.imem_rd, 0);
    tick();
    @(negedge clk);
    check("t5_resume_rd", bus.imem_rd, 1);
    check("t5_resume_addr", bus.imem_addr, 1);
    wait_valid(6, n);
    check("t5_resume_pc", bus.instr_pc, 1);

    // 6: reset while OUT with pc=9
    for (int k = 0; k < 10 && bus.instr_pc != 15'd7; k++) wait_valid(6, n);
    check("t6_reach7", bus.instr_pc, 7);
    tick();
    bus.instr_ready = 1'b0;
    wait_valid(6, n);
    check("t6_pc8", bus.instr_pc, 8);
    check("t6_pcreg9", bus.pc, 9);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_en_in_reset", bus.pc_enable, 0);
    check("t6_rd_in_reset", bus.imem_rd, 0);
    tick();
    reset           = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("t6_valid_dropped", bus.instr_valid, 0);
    check("t6_pc_zero", bus.pc, 0);
    wait_valid(6, n);
    check("t6_latency", n, 2);
    check("t6_first_pc", bus.instr_pc, 0);
    check("t6_first_instr", bus.instr, 16'h1111);

    // Random phase
    accepted = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      bus.instr_ready  = ($urandom_range(0, 3) != 0);
      bus.branch_taken = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.branch_target = 15'h7FFD + ADDR_W'($urandom_range(0, 2));
      else
        bus.branch_target = ADDR_W'($urandom);
      if ($urandom_range(0, 40) == 0) bus.halt = ~bus.halt;
      reset = ($urandom_range(0, 299) == 0);
    end
    tick();
    reset            = 1'b0;
    bus.branch_taken = 1'b0;
    bus.halt         = 1'b0;
    bus.instr_ready  = 1'b1;
    repeat (10) tick();
    check("rand_progress", (accepted > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
